alu_pipe: RTL and testbench

- Parametrised, handshaked successor to the combinational ALU opcode set in alu_pkg.
- Executes every ALU_OP_CODE on DATA_W-bit operands, with a registered result and status flags.
- Adds an iterative multiply (optional) and a tag passthrough.
- Sits between the instruction issue stage and writeback; valid/ready on both sides.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_seq_mul.sv | 67 ++++++
 rtl/alu_pipe.sv | 218 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types for the pipelined ALU. Holds the ALU opcode
//                set (including MULTIPLY), the packed status-flag record and
//                the multiply sequencer state encoding.
//                Opcodes 4'b1100..4'b1111 are unassigned and are reported as
//                illegal by alu_pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ADD            = 4'b0000,
    SUBTRACT       = 4'b0001,
    XOR            = 4'b0010,
    OR             = 4'b0011,
    AND            = 4'b0100,
    SHIFT_LT_LOG   = 4'b0101,
    SHIFT_RT_LOG   = 4'b0110,
    SHIFT_RT_AR    = 4'b0111,
    BARREL_SHIFTER = 4'b1000,
    IS_EQUAL       = 4'b1001,
    IS_GREATER     = 4'b1010,
    MULTIPLY       = 4'b1011
  } ALU_OP_CODE;

  // Bit order on the wire: [3]=zero, [2]=carry, [1]=overflow, [0]=error.
  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic error;
  } alu_flags_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } alu_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_mul
//  Description : Iterative unsigned DATA_W x DATA_W -> 2*DATA_W shift-add
//                multiplier, one partial-product step per clock.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                start             - load operands and begin (one cycle)
//                a, b              - multiplicand, multiplier
//                done              - high during the final step's cycle; the
//                                    product is complete after that edge
//                product           - {high half, low half}, held until the
//                                    next start
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_mul #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int                c_cnt_w = $clog2(DATA_W);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DATA_W - 1);

  logic                r_busy;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [DATA_W-1:0]   r_mcand;
  logic [DATA_W-1:0]   r_hi;
  // The low half starts as the multiplier and is shifted out LSB first while
  // product bits are shifted in from the top.
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W:0]     w_sum;

  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
  assign done    = r_busy && (r_cnt == c_last);
  assign product = {r_hi, r_lo};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
    end else if (r_busy) begin
      r_hi    <= w_sum[DATA_W:1];
      r_lo    <= {w_sum[0], r_lo[DATA_W-1:1]};
      r_cnt   <= r_cnt + 1'b1;
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Handshaked ALU with registered result, flags and tag.
//                Single-cycle ops retire one cycle after accept; MULTIPLY
//                (when built) runs DATA_W+1 cycles with in_ready held low.
//  Config      : `define ALU_MUL_EN to build the iterative multiplier.
//                Without it MULTIPLY is illegal and out_result_hi is 0.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                in_valid/in_ready          - request handshake
//                in_op, in_a, in_b, in_tag  - opcode, operands, tag
//                out_valid/out_ready        - result handshake
//                out_result, out_result_hi  - result / product halves
//                out_flags                  - {zero, carry, overflow, error}
//                out_tag                    - tag of this result
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_op,
  input  logic [DATA_W-1:0]   in_a,
  input  logic [DATA_W-1:0]   in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_result_hi,
  output alu_flags_t          out_flags,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int c_sh_w = $clog2(DATA_W);

  logic                  w_accept;
  logic                  w_single;
  logic                  w_idle;
  logic [c_sh_w-1:0]     w_sh;
  logic [DATA_W:0]       w_add;
  logic [DATA_W:0]       w_sub;
  logic [2*DATA_W-1:0]   w_rot;
  logic [DATA_W-1:0]     w_res;
  alu_flags_t            w_flags;

  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_result;
  alu_flags_t            r_flags;
  logic [TAG_W-1:0]      r_tag;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  assign in_ready = w_idle && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Single-cycle datapath
  // --------------------------------------------------------------------------
  assign w_sh  = in_b[c_sh_w-1:0];
  assign w_add = {1'b0, in_a} + {1'b0, in_b};
  assign w_sub = {1'b0, in_a} - {1'b0, in_b};
  // Rotate via a doubled operand: the top half after the shift is the
  // rotated value, and a zero amount falls out naturally.
  assign w_rot = {in_a, in_a} << w_sh;

  always_comb begin
    w_res   = '0;
    w_flags = '0;
    case (in_op)
      ADD: begin
        w_res            = w_add[DATA_W-1:0];
        w_flags.carry    = w_add[DATA_W];
        w_flags.overflow = (in_a[DATA_W-1] == in_b[DATA_W-1]) &&
                           (w_add[DATA_W-1] != in_a[DATA_W-1]);
      end
      SUBTRACT: begin
        // Bit DATA_W of the widened difference is the unsigned borrow.
        w_res            = w_sub[DATA_W-1:0];
        w_flags.carry    = w_sub[DATA_W];
        w_flags.overflow = (in_a[DATA_W-1] != in_b[DATA_W-1]) &&
                           (w_sub[DATA_W-1] != in_a[DATA_W-1]);
      end
      XOR:            w_res = in_a ^ in_b;
      OR:             w_res = in_a | in_b;
      AND:            w_res = in_a & in_b;
      SHIFT_LT_LOG:   w_res = in_a << w_sh;
      SHIFT_RT_LOG:   w_res = in_a >> w_sh;
      SHIFT_RT_AR:    w_res = $signed(in_a) >>> w_sh;
      BARREL_SHIFTER: w_res = w_rot[2*DATA_W-1:DATA_W];
      IS_EQUAL:       w_res = {{(DATA_W-1){1'b0}}, (in_a == in_b)};
      IS_GREATER:     w_res = {{(DATA_W-1){1'b0}}, (in_a > in_b)};
`ifdef ALU_MUL_EN
      MULTIPLY:       w_res = '0;   // handled by the sequencer
`endif
      default:        w_flags.error = 1'b1;
    endcase
    // Illegal ops report error alone, so zero stays clear for them.
    if (!w_flags.error) begin
      w_flags.zero = (w_res == '0);
    end
  end

`ifdef ALU_MUL_EN
  // --------------------------------------------------------------------------
  // Multiply sequencer
  // --------------------------------------------------------------------------
  alu_state_t            r_state;
  alu_state_t            w_state_next;
  logic                  w_mul_start;
  logic                  w_mul_done;
  logic                  w_mul_load;
  logic [2*DATA_W-1:0]   w_product;
  alu_flags_t            w_mul_flags;
  logic [TAG_W-1:0]      r_mul_tag;
  logic [DATA_W-1:0]     r_result_hi;

  assign w_mul_start = w_accept && (in_op == MULTIPLY);
  assign w_single    = w_accept && !w_mul_start;
  assign w_idle      = (r_state == IDLE);
  assign w_mul_load  = (r_state == MUL_DONE);

  alu_seq_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_mul_tag <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_mul_start) begin
        r_mul_tag <= in_tag;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (w_mul_start) w_state_next = MUL_RUN;
      MUL_RUN:  if (w_mul_done)  w_state_next = MUL_DONE;
      MUL_DONE: w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_mul_flags      = '0;
    w_mul_flags.zero = (w_product == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_result_hi <= '0;
    end else if (w_single) begin
      r_result_hi <= '0;
    end else if (w_mul_load) begin
      r_result_hi <= w_product[2*DATA_W-1:DATA_W];
    end
  end

  assign out_result_hi = r_result_hi;
`else
  assign w_single      = w_accept;
  assign w_idle        = 1'b1;
  assign out_result_hi = '0;
`endif

  // --------------------------------------------------------------------------
  // Output register. A single-cycle accept may coincide with the consumer
  // taking the previous result; the load then wins and out_valid stays high.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_tag       <= '0;
    end else if (w_single) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_flags     <= w_flags;
      r_tag       <= in_tag;
`ifdef ALU_MUL_EN
    end else if (w_mul_load) begin
      r_out_valid <= 1'b1;
      r_result    <= w_product[DATA_W-1:0];
      r_flags     <= w_mul_flags;
      r_tag       <= r_mul_tag;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;
  assign out_tag    = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe at DATA_W=8, TAG_W=4.
//                Table of single-cycle vectors plus hand-written sequences
//                for throughput, backpressure, multiply and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [3:0]     in_op;
  logic [DW-1:0]  in_a;
  logic [DW-1:0]  in_b;
  logic [TW-1:0]  in_tag;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_result;
  logic [DW-1:0]  out_result_hi;
  logic [3:0]     out_flags;
  logic [TW-1:0]  out_tag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_pipe #(
    .DATA_W (DW),
    .TAG_W  (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_op         (in_op),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_tag        (in_tag),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_result_hi (out_result_hi),
    .out_flags     (out_flags),
    .out_tag       (out_tag)
  );

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    logic [DW-1:0] res;
    logic [DW-1:0] hi;
    logic [3:0]    flags;   // {zero, carry, overflow, error}
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] op, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [TW-1:0] tag,
                              input logic [DW-1:0] res, input logic [3:0] flags);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.tag = tag;
    v.res = res; v.hi = '0; v.flags = flags;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [DW-1:0] res,
                         input logic [DW-1:0] hi, input logic [3:0] flags,
                         input logic [TW-1:0] tag);
    chk({name, ".valid"}, 32'(out_valid), 32'd1);
    chk({name, ".res"},   32'(out_result), 32'(res));
    chk({name, ".hi"},    32'(out_result_hi), 32'(hi));
    chk({name, ".flags"}, 32'(out_flags), 32'(flags));
    chk({name, ".tag"},   32'(out_tag), 32'(tag));
  endtask

  // Present a request and hold it for one rising edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [TW-1:0] tag);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic saw_valid;

    // Flags column is {zero, carry, overflow, error}.
    vecs.push_back(mk(ADD,            8'hFF, 8'h01, 4'd3, 8'h00, 4'b1100));
    vecs.push_back(mk(ADD,            8'h7F, 8'h01, 4'd1, 8'h80, 4'b0010));
    vecs.push_back(mk(SUBTRACT,       8'h80, 8'h01, 4'd2, 8'h7F, 4'b0010));
    vecs.push_back(mk(SUBTRACT,       8'h01, 8'h02, 4'd4, 8'hFF, 4'b0100));
    vecs.push_back(mk(XOR,            8'hF0, 8'hFF, 4'd5, 8'h0F, 4'b0000));
    vecs.push_back(mk(OR,             8'h0C, 8'h30, 4'd6, 8'h3C, 4'b0000));
    vecs.push_back(mk(AND,            8'hF0, 8'h0F, 4'd7, 8'h00, 4'b1000));
    vecs.push_back(mk(SHIFT_LT_LOG,   8'h81, 8'h01, 4'd8, 8'h02, 4'b0000));
    vecs.push_back(mk(SHIFT_RT_LOG,   8'h81, 8'h01, 4'd9, 8'h40, 4'b0000));
    vecs.push_back(mk(SHIFT_RT_AR,    8'h80, 8'h03, 4'd10, 8'hF0, 4'b0000));
    vecs.push_back(mk(BARREL_SHIFTER, 8'h81, 8'h01, 4'd11, 8'h03, 4'b0000));
    // Shift amount uses only the low 3 bits: 8 rotates by 0.
    vecs.push_back(mk(BARREL_SHIFTER, 8'h5A, 8'h08, 4'd12, 8'h5A, 4'b0000));
    vecs.push_back(mk(IS_EQUAL,       8'h05, 8'h05, 4'd13, 8'h01, 4'b0000));
    vecs.push_back(mk(IS_GREATER,     8'h03, 8'h05, 4'd14, 8'h00, 4'b1000));
    vecs.push_back(mk(IS_GREATER,     8'h80, 8'h7F, 4'd15, 8'h01, 4'b0000));
    vecs.push_back(mk(4'hC,           8'h12, 8'h34, 4'd0, 8'h00, 4'b0001));
    vecs.push_back(mk(4'hF,           8'h12, 8'h34, 4'd1, 8'h00, 4'b0001));
`ifndef ALU_MUL_EN
    vecs.push_back(mk(MULTIPLY,       8'd200, 8'd3, 4'd2, 8'h00, 4'b0001));
`endif

    // ---------------- reset ----------------
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready",  32'(in_ready), 32'd1);
    chk("rst.result",    32'(out_result), 32'd0);
    chk("rst.hi",        32'(out_result_hi), 32'd0);
    chk("rst.flags",     32'(out_flags), 32'd0);
    chk("rst.tag",       32'(out_tag), 32'd0);

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      chk($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'd1);
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
      chk_out($sformatf("v%0d", i), vecs[i].res, vecs[i].hi, vecs[i].flags, vecs[i].tag);
    end
    @(posedge clk); #1;
    chk("idle.out_valid", 32'(out_valid), 32'd0);

    // ---------------- back-to-back throughput ----------------
    in_valid = 1'b1; in_op = ADD; in_a = 8'd1; in_b = 8'd1; in_tag = 4'd1;
    @(posedge clk); #1;
    chk_out("bb1", 8'h02, 8'h00, 4'b0000, 4'd1);
    chk("bb1.in_ready", 32'(in_ready), 32'd1);
    in_op = ADD; in_a = 8'd2; in_b = 8'd2; in_tag = 4'd2;
    @(posedge clk); #1;
    chk_out("bb2", 8'h04, 8'h00, 4'b0000, 4'd2);
    in_op = XOR; in_a = 8'd3; in_b = 8'd1; in_tag = 4'd3;
    @(posedge clk); #1;
    chk_out("bb3", 8'h02, 8'h00, 4'b0000, 4'd3);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bb.drain", 32'(out_valid), 32'd0);

    // ---------------- backpressure ----------------
    out_ready = 1'b0;
    issue(ADD, 8'h10, 8'h20, 4'd7);
    in_valid = 1'b1; in_op = SUBTRACT; in_a = 8'h09; in_b = 8'h04; in_tag = 4'd8;
    for (int k = 0; k < 5; k++) begin
      chk_out($sformatf("bp%0d", k), 8'h30, 8'h00, 4'b0000, 4'd7);
      chk($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp.release.in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp.new", 8'h05, 8'h00, 4'b0000, 4'd8);
    @(posedge clk); #1;
    chk("bp.drain", 32'(out_valid), 32'd0);

`ifdef ALU_MUL_EN
    // ---------------- multiply ----------------
    issue(MULTIPLY, 8'd200, 8'd3, 4'd5);
    chk("mul.acc.in_ready", 32'(in_ready), 32'd0);
    chk("mul.acc.valid", 32'(out_valid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mul.c%0d.valid", k), 32'(out_valid), 32'd0);
      chk($sformatf("mul.c%0d.in_ready", k), 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk_out("mul", 8'h58, 8'h02, 4'b0000, 4'd5);
    @(posedge clk); #1;
    chk("mul.drain", 32'(out_valid), 32'd0);
    chk("mul.in_ready", 32'(in_ready), 32'd1);
`endif

    // ---------------- reset mid-operation ----------------
    // With the multiplier built this aborts a running MULTIPLY; without it
    // the error result is stalled and then discarded.
    out_ready = 1'b0;
    issue(MULTIPLY, 8'd200, 8'd3, 4'd6);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid.pre.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    chk("rst_mid.valid", 32'(out_valid), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid.result", 32'(out_result), 32'd0);
    saw_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (out_valid) saw_valid = 1'b1;
    end
    chk("rst_mid.no_result", 32'(saw_valid), 32'd0);
    issue(ADD, 8'd2, 8'd2, 4'd9);
    chk_out("rst_mid.add", 8'h04, 8'h00, 4'b0000, 4'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
